multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/multdiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue controller and the
// multdiv datapath: controller state encoding, default writeback
// register for exceptions, and default exception status codes.
package multdiv_pkg;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_t;

  localparam int MD_TIMEOUT_DEF = 64;
  localparam int MD_RSTATUS_DEF = 30;
  localparam int MD_MUL_EXC_DEF = 4;
  localparam int MD_DIV_EXC_DEF = 5;

  // Status code written back when a multiply or divide ends in an exception.
  function automatic logic [31:0] md_exc_code(input logic is_div,
                                              input int   mul_exc,
                                              input int   div_exc);
    return is_div ? 32'(div_exc) : 32'(mul_exc);
  endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller for the iterative multiply/divide unit.
// Accepts one operation from the execute stage, pulses the multdiv start
// control for one cycle, waits (bounded by TIMEOUT) for md_ready, then
// raises a one-cycle writeback request. An exception from multdiv, or a
// timeout, redirects the writeback to RSTATUS with a status code.
//
// Ports
//   clock, reset_n              : clock, synchronous active-low reset
//   op_valid/op_is_div/op_a/op_b/op_rd : issue request from execute
//   flush                       : squash the in-flight operation
//   stall                       : hold the upstream pipeline
//   md_operandA/B, md_ctrl_Mult/Div : operands and start pulse to multdiv
//   md_result/md_except/md_ready    : completion from multdiv
//   wb_valid/wb_rd/wb_data      : writeback request
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MD_IDLE  | no op in flight; accepts op_valid when not flushed
// MD_START | start pulse to multdiv (suppressed by flush); md_ready ignored
// MD_WAIT  | counting cycles until md_ready, timeout or flush
// MD_DONE  | one-cycle writeback; flush ignored (belongs to older insn)
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = MD_TIMEOUT_DEF,
  parameter int RSTATUS = MD_RSTATUS_DEF,
  parameter int MUL_EXC = MD_MUL_EXC_DEF,
  parameter int DIV_EXC = MD_DIV_EXC_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_Mult,
  output logic        md_ctrl_Div,
  input  logic [31:0] md_result,
  input  logic        md_except,
  input  logic        md_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int              CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [4:0]      RSTATUS_RD = 5'(RSTATUS);

  md_state_t     state;
  logic [CW-1:0] wait_cnt;
  logic          div_q;
  logic [4:0]    rd_q;

  logic          wait_end;
  logic          end_exc;
  logic [4:0]    wb_rd_nxt;
  logic [31:0]   wb_data_nxt;

  // A timeout is reported exactly like an exception from multdiv.
  assign wait_end    = md_ready || (wait_cnt == CNT_LAST);
  assign end_exc     = md_ready ? md_except : 1'b1;
  assign wb_rd_nxt   = end_exc ? RSTATUS_RD : rd_q;
  assign wb_data_nxt = end_exc ? md_exc_code(div_q, MUL_EXC, DIV_EXC) : md_result;

  // Stall must cover the accept cycle combinationally so the op is not
  // replaced upstream before it is latched.
  assign stall = ((state == MD_IDLE) && op_valid) ||
                 (state == MD_START) || (state == MD_WAIT);

  // The start pulse is gated by flush in the same cycle, so it cannot be
  // a registered output.
  assign md_ctrl_Mult = (state == MD_START) && !flush && !div_q;
  assign md_ctrl_Div  = (state == MD_START) && !flush &&  div_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= MD_IDLE;
      wait_cnt    <= '0;
      div_q       <= 1'b0;
      rd_q        <= '0;
      md_operandA <= '0;
      md_operandB <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (op_valid && !flush) begin
            md_operandA <= op_a;
            md_operandB <= op_b;
            div_q       <= op_is_div;
            rd_q        <= op_rd;
            state       <= MD_START;
          end
        end

        MD_START: begin
          wait_cnt <= '0;
          if (flush) begin
            md_operandA <= '0;
            md_operandB <= '0;
            state       <= MD_IDLE;
          end else begin
            state <= MD_WAIT;
          end
        end

        MD_WAIT: begin
          // flush wins over a same-cycle md_ready
          if (flush) begin
            md_operandA <= '0;
            md_operandB <= '0;
            state       <= MD_IDLE;
          end else if (wait_end) begin
            md_operandA <= '0;
            md_operandB <= '0;
            wb_valid    <= 1'b1;
            wb_rd       <= wb_rd_nxt;
            wb_data     <= wb_data_nxt;
            state       <= MD_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        MD_DONE: begin
          wb_valid <= 1'b0;
          wb_rd    <= '0;
          wb_data  <= '0;
          state    <= MD_IDLE;
        end

        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl. Each operation is described at the
// transaction level (operands, when multdiv answers, flush/reset points);
// run_op walks the issue/start/wait/writeback timeline and publishes the
// expected outputs for every cycle, which one negedge process compares.
module tb_multdiv_ctrl;

  localparam int TMO = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        op_valid, op_is_div, flush;
  logic [31:0] op_a, op_b, md_result;
  logic [4:0]  op_rd;
  logic        md_except, md_ready;
  logic        stall, md_ctrl_Mult, md_ctrl_Div, wb_valid;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0]  wb_rd;

  always #5 clock = ~clock;

  multdiv_ctrl #(.TIMEOUT(TMO), .RSTATUS(30), .MUL_EXC(4), .DIV_EXC(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .op_valid(op_valid), .op_is_div(op_is_div), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .flush(flush), .stall(stall),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_Mult(md_ctrl_Mult), .md_ctrl_Div(md_ctrl_Div),
    .md_result(md_result), .md_except(md_except), .md_ready(md_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  logic        e_stall, e_mul, e_div, e_wbv;
  logic [31:0] e_a, e_b, e_data;
  logic [4:0]  e_rd;

  int cyc = 0, mul_pulses = 0, div_pulses = 0, wbv_cnt = 0;
  int pulse_cyc = 0, wbv_cyc = 0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;
  int m0, d0, w0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (md_ctrl_Mult === 1'b1) begin mul_pulses++; pulse_cyc = cyc; end
    if (md_ctrl_Div === 1'b1)  begin div_pulses++; pulse_cyc = cyc; end
    if (wb_valid === 1'b1) begin
      wbv_cnt++; wbv_cyc = cyc; last_rd = wb_rd; last_data = wb_data;
    end
    if (chk_en) begin
      check("stall",        32'(stall),        32'(e_stall));
      check("md_ctrl_Mult", 32'(md_ctrl_Mult), 32'(e_mul));
      check("md_ctrl_Div",  32'(md_ctrl_Div),  32'(e_div));
      check("md_operandA",  md_operandA,       e_a);
      check("md_operandB",  md_operandB,       e_b);
      check("wb_valid",     32'(wb_valid),     32'(e_wbv));
      check("wb_rd",        32'(wb_rd),        32'(e_rd));
      check("wb_data",      wb_data,           e_data);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_idle();
    e_stall = 1'b0; e_mul = 1'b0; e_div = 1'b0; e_wbv = 1'b0;
    e_a = '0; e_b = '0; e_rd = '0; e_data = '0;
  endtask

  task automatic snap();
    m0 = mul_pulses; d0 = div_pulses; w0 = wbv_cnt;
  endtask

  // flush_at: -2 none, -1 in START, k>=0 in the k-th WAIT cycle.
  // ready_at: WAIT cycle index where multdiv answers, -1 never.
  // rst_at:   WAIT cycle index where reset_n drops for two edges, -1 never.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic div,
                        input logic [4:0] rd, input int ready_at, input logic exc,
                        input int flush_at, input int rst_at, input logic flush_done);
    logic [31:0] res;
    logic        done_exc;
    logic        ended;
    res = div ? ((b != 0) ? a / b : 32'hFFFF_FFFF) : a * b;

    op_valid = 1'b1; op_is_div = div; op_a = a; op_b = b; op_rd = rd;
    md_ready = 1'b0; flush = 1'b0;
    exp_idle(); e_stall = 1'b1;
    step();
    op_valid = 1'b0; op_is_div = !div; op_a = ~a; op_b = ~b; op_rd = ~rd;

    // stale ready in the start cycle must be ignored
    md_ready = 1'b1; md_except = 1'b1; md_result = 32'hBAD0_0000;
    flush = (flush_at == -1);
    e_stall = 1'b1; e_a = a; e_b = b; e_wbv = 1'b0; e_rd = '0; e_data = '0;
    e_mul = !div && !flush; e_div = div && !flush;
    step();
    flush = 1'b0; md_ready = 1'b0;
    if (flush_at == -1) begin exp_idle(); return; end

    ended = 1'b0; done_exc = 1'b0;
    for (int k = 0; k < TMO && !ended; k++) begin
      e_mul = 1'b0; e_div = 1'b0; e_stall = 1'b1; e_a = a; e_b = b;
      md_ready  = (k == ready_at);
      md_except = md_ready ? exc : 1'b1;
      md_result = md_ready ? res : 32'hDEAD_BEEF;
      flush     = (k == flush_at);
      if (k == rst_at) reset_n = 1'b0;
      step();
      md_ready = 1'b0; flush = 1'b0;
      if (k == rst_at) begin
        exp_idle();
        step();
        reset_n = 1'b1;
        return;
      end
      if (k == flush_at) begin exp_idle(); return; end
      if (k == ready_at) begin ended = 1'b1; done_exc = exc; end
      else if (k == TMO - 1) begin ended = 1'b1; done_exc = 1'b1; end
    end

    e_stall = 1'b0; e_wbv = 1'b1; e_a = '0; e_b = '0;
    e_rd   = done_exc ? 5'd30 : rd;
    e_data = done_exc ? (div ? 32'd5 : 32'd4) : res;
    flush  = flush_done;
    step();
    flush = 1'b0;
    exp_idle();
  endtask

  initial begin
    reset_n = 1'b0; op_valid = 1'b0; op_is_div = 1'b0; op_a = '0; op_b = '0; op_rd = '0;
    flush = 1'b0; md_result = '0; md_except = 1'b0; md_ready = 1'b0;
    exp_idle();
    step();
    chk_en = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    step();
    check("rst_pulses", 32'(mul_pulses + div_pulses), 32'd0);
    check("rst_wb_count", 32'(wbv_cnt), 32'd0);

    // 7 x -3 -> rd5 = -21, multdiv answers in the 33rd wait cycle
    snap();
    run_op(32'd7, 32'hFFFF_FFFD, 1'b0, 5'd5, 32, 1'b0, -2, -1, 1'b0);
    check("m7_mul_pulses", 32'(mul_pulses - m0), 32'd1);
    check("m7_div_pulses", 32'(div_pulses - d0), 32'd0);
    check("m7_wb_count",   32'(wbv_cnt - w0),    32'd1);
    check("m7_wb_rd",      32'(last_rd),         32'd5);
    check("m7_wb_data",    last_data,            32'hFFFF_FFEB);
    check("m7_latency",    32'(wbv_cyc - pulse_cyc), 32'd34);
    step();

    // 100 / 0 with exception
    snap();
    run_op(32'd100, 32'd0, 1'b1, 5'd9, 3, 1'b1, -2, -1, 1'b0);
    check("div0_div_pulses", 32'(div_pulses - d0), 32'd1);
    check("div0_wb_rd",   32'(last_rd), 32'd30);
    check("div0_wb_data", last_data,    32'd5);
    step();

    // 0x7FFFFFFF x 2 with exception
    run_op(32'h7FFF_FFFF, 32'd2, 1'b0, 5'd11, 5, 1'b1, -2, -1, 1'b0);
    check("movf_wb_rd",   32'(last_rd), 32'd30);
    check("movf_wb_data", last_data,    32'd4);
    step();

    // flush on the same cycle as md_ready
    snap();
    run_op(32'd6, 32'd6, 1'b0, 5'd7, 4, 1'b0, 4, -1, 1'b0);
    step();
    check("fwait_wb_count", 32'(wbv_cnt - w0), 32'd0);

    // timeout, mult
    snap();
    run_op(32'd3, 32'd5, 1'b0, 5'd8, -1, 1'b0, -2, -1, 1'b0);
    check("tmo_latency",  32'(wbv_cyc - pulse_cyc), 32'd65);
    check("tmo_wb_rd",    32'(last_rd), 32'd30);
    check("tmo_wb_data",  last_data,    32'd4);
    step();

    // flush in start: no pulse, no writeback
    snap();
    run_op(32'd10, 32'd2, 1'b1, 5'd4, 0, 1'b0, -1, -1, 1'b0);
    step();
    check("fstart_pulses",   32'(mul_pulses + div_pulses - m0 - d0), 32'd0);
    check("fstart_wb_count", 32'(wbv_cnt - w0), 32'd0);

    // rd = 0, immediate ready, flush during writeback is ignored
    snap();
    run_op(32'd3, 32'd4, 1'b0, 5'd0, 0, 1'b0, -2, -1, 1'b1);
    check("r0_wb_count", 32'(wbv_cnt - w0), 32'd1);
    check("r0_wb_rd",    32'(last_rd),      32'd0);
    check("r0_wb_data",  last_data,         32'd12);
    step();

    // reset during wait, then two back-to-back ops right after release
    snap();
    run_op(32'd1, 32'd1, 1'b0, 5'd2, -1, 1'b0, -2, 10, 1'b0);
    check("rst_wait_wb_count", 32'(wbv_cnt - w0), 32'd0);
    snap();
    run_op(32'd50, 32'd7, 1'b1, 5'd12, 2, 1'b0, -2, -1, 1'b0);
    check("b2b1_wb_data", last_data, 32'd7);
    run_op(32'd6, 32'd9, 1'b0, 5'd3, 1, 1'b0, -2, -1, 1'b0);
    step();
    check("b2b_mul_pulses", 32'(mul_pulses - m0), 32'd1);
    check("b2b_div_pulses", 32'(div_pulses - d0), 32'd1);
    check("b2b_wb_count",   32'(wbv_cnt - w0),    32'd2);
    check("b2b2_wb_rd",     32'(last_rd),         32'd3);
    check("b2b2_wb_data",   last_data,            32'd54);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
